// File: rtl/jk_cmd_gen.sv
// jk_cmd_gen -- turns two bouncy push buttons ("set", "clear") into single
// one-cycle J/K commands for a downstream JK flip-flop.
//
// Each button is synchronized and debounced. A press of one button waits up
// to PAIR_WINDOW cycles for the other button. If both are pressed together
// the result is a toggle (J=K=1). A lone set gives J, and a lone clear gives K.
// After a command the block holds until both buttons are released.
//
// Ports:
//   iClk     clock, rising edge
//   iRst     synchronous active-high reset
//   iBtnSet  raw set button (asynchronous, bouncy)
//   iBtnClr  raw clear button (asynchronous, bouncy)
//   oJ, oK   registered one-cycle command pulse
//   oBusy    high in any state other than IDLE

// Per-button front end. It contains a 2-flop synchronizer, a debounce counter
// and a press detector.
module jk_cmd_gen_db #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iBtn,
  output logic oLvl,
  output logic oPress
);
  localparam int CNT_W = 8;

  logic             sync1_q, sync2_q;
  logic             lvl_q, lvl_d, lvl_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The stable level follows the synchronized input only after the input has
  // disagreed with it for DEBOUNCE_CYCLES cycles in a row. Any cycle in which
  // the two agree restarts the count.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= iBtn;
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      cnt_q      <= cnt_d;
    end
  end

  assign oLvl   = lvl_q;
  assign oPress = lvl_q & ~lvl_prev_q;  // high for one cycle after a 0->1 change
endmodule

module jk_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PAIR_WINDOW     = 4
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iBtnSet,
  input  logic iBtnClr,
  output logic oJ,
  output logic oK,
  output logic oBusy
);
  localparam int NUM_CH = 2;
  localparam int CH_SET = 0;
  localparam int CH_CLR = 1;
  localparam int WIN_W  = 8;

  typedef enum logic [2:0] {IDLE, WAIT_CLR, WAIT_SET, EMIT, HOLD} state_e;

  logic [NUM_CH-1:0] btn, lvl, press;

  assign btn = {iBtnClr, iBtnSet};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    jk_cmd_gen_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .iClk   (iClk),
      .iRst   (iRst),
      .iBtn   (btn[g]),
      .oLvl   (lvl[g]),
      .oPress (press[g])
    );
  end

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [1:0]       code_q, code_d;    // {J, K} latched for EMIT
  logic             j_q, k_q;

  // A WAIT state lasts PAIR_WINDOW cycles. The window counter counts down
  // from PAIR_WINDOW, and the FSM leaves the WAIT state on the cycle the
  // counter would reach 0. A partner press on that last cycle still wins
  // over expiry, so the result is a toggle.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (press[CH_SET] && press[CH_CLR]) begin
          state_d = EMIT;
          code_d  = 2'b11;
        end else if (press[CH_SET]) begin
          state_d = WAIT_CLR;
          win_d   = WIN_W'(PAIR_WINDOW);
        end else if (press[CH_CLR]) begin
          state_d = WAIT_SET;
          win_d   = WIN_W'(PAIR_WINDOW);
        end
      end
      WAIT_CLR: begin
        if (press[CH_CLR]) begin
          state_d = EMIT;
          code_d  = 2'b11;
        end else if (win_q <= WIN_W'(1)) begin
          state_d = EMIT;
          code_d  = 2'b10;
          win_d   = '0;
        end else begin
          win_d   = win_q - WIN_W'(1);
        end
      end
      WAIT_SET: begin
        if (press[CH_SET]) begin
          state_d = EMIT;
          code_d  = 2'b11;
        end else if (win_q <= WIN_W'(1)) begin
          state_d = EMIT;
          code_d  = 2'b01;
          win_d   = '0;
        end else begin
          win_d   = win_q - WIN_W'(1);
        end
      end
      EMIT:    state_d = HOLD;
      // Presses seen here are dropped. The FSM re-arms only after both
      // buttons are released.
      HOLD:    if (lvl == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      win_q   <= '0;
      code_q  <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      code_q  <= code_d;
      // The output flops are loaded from the next state. The pulse therefore
      // lines up exactly with the EMIT cycle.
      j_q     <= (state_d == EMIT) & code_d[1];
      k_q     <= (state_d == EMIT) & code_d[0];
    end
  end

  assign oJ    = j_q;
  assign oK    = k_q;
  assign oBusy = (state_q != IDLE);
endmodule

// File: tb/tb_jk_cmd_gen.sv
// Directed bench for jk_cmd_gen with DEBOUNCE_CYCLES=4 and PAIR_WINDOW=3.
// Stimulus is applied 1 time unit after a rising edge. "Edge k" means the k-th
// rising edge after the first stimulus change of a scenario. Outputs are
// sampled 1 time unit after each edge.
module tb_jk_cmd_gen;
  logic iClk = 1'b0;
  logic iRst, iBtnSet, iBtnClr;
  logic oJ, oK, oBusy;
  logic ej, ek, eb;
  int   checks   = 0;
  int   failures = 0;

  jk_cmd_gen #(.DEBOUNCE_CYCLES(4), .PAIR_WINDOW(3)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iBtnSet (iBtnSet),
    .iBtnClr (iBtnClr),
    .oJ      (oJ),
    .oK      (oK),
    .oBusy   (oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic cyc();
    @(posedge iClk);
    #1;
  endtask

  // Releases both buttons and waits a bounded time for the block to go idle.
  task automatic settle();
    iBtnSet = 1'b0;
    iBtnClr = 1'b0;
    for (int i = 0; i < 40 && oBusy !== 1'b0; i++) cyc();
    for (int i = 0; i < 8; i++) cyc();
  endtask

  task automatic test_reset();
    iRst = 1'b1; iBtnSet = 1'b0; iBtnClr = 1'b0;
    cyc(); cyc();
    checks++;
    if ({oJ, oK, oBusy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs got jkb=%b%b%b want 000", oJ, oK, oBusy);
    end
    iRst = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    checks++;
    if ({oJ, oK, oBusy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_release got jkb=%b%b%b want 000", oJ, oK, oBusy);
    end
  endtask

  // Lone set press, held for 20 cycles. Expect J at edge 10 and busy on edges 7..26.
  task automatic test_lone_set();
    iBtnSet = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      ej = (k == 10); ek = 1'b0; eb = (k >= 7 && k <= 26);
      checks++;
      if ({oJ, oK} !== {ej, ek}) begin
        failures++;
        $display("FAIL lone_set_jk k=%0d got %b%b want %b%b", k, oJ, oK, ej, ek);
      end
      checks++;
      if (oBusy !== eb) begin
        failures++;
        $display("FAIL lone_set_busy k=%0d got %b want %b", k, oBusy, eb);
      end
      if (k == 20) iBtnSet = 1'b0;
    end
  endtask

  // Set button toggles every 2 cycles. It never stays stable long enough to
  // pass the debounce.
  task automatic test_bounce();
    iBtnSet = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      checks++;
      if ({oJ, oK, oBusy} !== 3'b000) begin
        failures++;
        $display("FAIL bounce k=%0d got jkb=%b%b%b want 000", k, oJ, oK, oBusy);
      end
      if (k <= 10 && (k % 2) == 0) iBtnSet = ~iBtnSet;
      if (k == 12) iBtnSet = 1'b0;
    end
  endtask

  // Clear press, then set press 2 cycles later. Expect one toggle at edge 9.
  task automatic test_pair_clr_first();
    iBtnClr = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      ej = (k == 9); ek = (k == 9); eb = (k >= 7 && k <= 20);
      checks++;
      if ({oJ, oK} !== {ej, ek}) begin
        failures++;
        $display("FAIL pair_clr_first_jk k=%0d got %b%b want %b%b", k, oJ, oK, ej, ek);
      end
      checks++;
      if (oBusy !== eb) begin
        failures++;
        $display("FAIL pair_clr_first_busy k=%0d got %b want %b", k, oBusy, eb);
      end
      if (k == 2) iBtnSet = 1'b1;
      if (k == 14) begin iBtnSet = 1'b0; iBtnClr = 1'b0; end
    end
  endtask

  // Both buttons pressed in the same cycle. Expect a toggle 1 cycle after the
  // press events.
  task automatic test_same_cycle();
    iBtnSet = 1'b1; iBtnClr = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      cyc();
      ej = (k == 7); ek = (k == 7); eb = (k >= 7 && k <= 18);
      checks++;
      if ({oJ, oK, oBusy} !== {ej, ek, eb}) begin
        failures++;
        $display("FAIL same_cycle k=%0d got jkb=%b%b%b want %b%b%b", k, oJ, oK, oBusy, ej, ek, eb);
      end
      if (k == 12) begin iBtnSet = 1'b0; iBtnClr = 1'b0; end
    end
  endtask

  // Clear is pressed while the block is in HOLD. The press is ignored and
  // there is only one J pulse.
  task automatic test_hold_ignore();
    iBtnSet = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      cyc();
      ej = (k == 10); ek = 1'b0; eb = (k >= 7 && k <= 46);
      checks++;
      if ({oJ, oK, oBusy} !== {ej, ek, eb}) begin
        failures++;
        $display("FAIL hold_ignore k=%0d got jkb=%b%b%b want %b%b%b", k, oJ, oK, oBusy, ej, ek, eb);
      end
      if (k == 15) iBtnClr = 1'b1;
      if (k == 40) begin iBtnSet = 1'b0; iBtnClr = 1'b0; end
    end
  endtask

  // Lone clear press. Expect K only, at edge 10.
  task automatic test_lone_clr();
    iBtnClr = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      ej = 1'b0; ek = (k == 10); eb = (k >= 7 && k <= 20);
      checks++;
      if ({oJ, oK, oBusy} !== {ej, ek, eb}) begin
        failures++;
        $display("FAIL lone_clr k=%0d got jkb=%b%b%b want %b%b%b", k, oJ, oK, oBusy, ej, ek, eb);
      end
      if (k == 14) iBtnClr = 1'b0;
    end
  endtask

  // The partner press arrives lag cycles after set. lag=3 lands on the last
  // window cycle and counts as a pair. lag=4 is too late, so set is issued
  // alone and the late clear is dropped.
  task automatic test_window_edge(input int lag);
    iBtnSet = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      ej = (k == 10); ek = (k == 10) && (lag == 3); eb = (k >= 7 && k <= 20);
      checks++;
      if ({oJ, oK, oBusy} !== {ej, ek, eb}) begin
        failures++;
        $display("FAIL window_edge lag=%0d k=%0d got jkb=%b%b%b want %b%b%b",
                 lag, k, oJ, oK, oBusy, ej, ek, eb);
      end
      if (k == lag) iBtnClr = 1'b1;
      if (k == 14) begin iBtnSet = 1'b0; iBtnClr = 1'b0; end
    end
  endtask

  // Reset is pulsed during WAIT_CLR. The pending J is dropped. The set button
  // is still held, so it debounces again and gives J 10 edges after reset.
  task automatic test_reset_wait();
    iBtnSet = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      cyc();
      ej = (k == 18); ek = 1'b0; eb = (k == 7) || (k >= 15 && k <= 30);
      checks++;
      if ({oJ, oK, oBusy} !== {ej, ek, eb}) begin
        failures++;
        $display("FAIL reset_wait k=%0d got jkb=%b%b%b want %b%b%b", k, oJ, oK, oBusy, ej, ek, eb);
      end
      iRst = (k == 7);
      if (k == 24) iBtnSet = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_lone_set();      settle();
    test_bounce();        settle();
    test_pair_clr_first(); settle();
    test_same_cycle();    settle();
    test_hold_ignore();   settle();
    test_lone_clr();      settle();
    test_window_edge(3);  settle();
    test_window_edge(4);  settle();
    test_reset_wait();    settle();
    checks++;
    if ({oJ, oK, oBusy} !== 3'b000) begin
      failures++;
      $display("FAIL final_idle got jkb=%b%b%b want 000", oJ, oK, oBusy);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
